irrigation_sequencer: RTL and testbench
=======================================

IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter SETTLE_TICKS, default 3, dry-soil confirmation time in ticks (legal 1..255).
REQ-002 Parameter SPLINKER_SECONDS, default 30, sprinkler run time in ticks (legal 1..255).
REQ-003 Parameter DRIPPER_SECONDS, default 90, dripper run time in ticks (legal 1..255).
REQ-004 Parameter COOLDOWN_SECONDS, default 10, post-irrigation lockout in ticks (legal 1..255).
REQ-005 clock  input  1  single system clock; all state SHALL change on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 tick  input  1  one-clock-wide 1 Hz enable; the only event that advances counters.
REQ-008 low_water_level, mid_water_level, high_water_level  input  1 each  tank level sensors, 1 = water present at that level.
REQ-009 earth_humidity  input  1  1 = soil dry, irrigation wanted.
REQ-010 air_humidity, low_temperature  input  1 each  1 = humid air / cold; either one forbids sprinkler mode.
REQ-011 stop  input  1  one-clock manual abort request.
REQ-012 splinker_bomb, dripper_valvule, water_supply_valvule  output  1 each  actuator enables, 1 = on.
REQ-013 alarm  output  1  fault or low-level warning.
REQ-014 state  output  3  encoded FSM state.
REQ-015 remaining_seconds  output  8  current countdown value.
REQ-016 cycle_done  output  1  one-clock pulse when a completed cycle returns to IDLE.

Function
REQ-017 The conflict signal SHALL be (mid & ~low) | (high & ~mid), evaluated combinationally every clock.
REQ-018 States SHALL be IDLE=0, SETTLE=1, IRRIGATE=2, COOLDOWN=3, REFILL=4, FAULT=5; codes 6-7 SHALL go to FAULT next clock.
REQ-019 Per-clock priority SHALL be: conflict > low-water abort > stop > tick.
REQ-020 From any state except FAULT, conflict SHALL force FAULT next clock, without waiting for tick.
REQ-021 In FAULT, a tick with conflict=0 SHALL move to IDLE; remaining_seconds SHALL be 0.
REQ-022 In IDLE, low=0 SHALL move to REFILL; otherwise earth_humidity=1 SHALL move to SETTLE and load SETTLE_TICKS.
REQ-023 In SETTLE, earth_humidity=0 or stop SHALL return to IDLE; otherwise each tick decrements; a tick at value 1 SHALL enter IRRIGATE.
REQ-024 On SETTLE->IRRIGATE, mode SHALL latch as sprinkler iff mid & ~air_humidity & ~low_temperature, else dripper; load SPLINKER_SECONDS or DRIPPER_SECONDS accordingly.
REQ-025 Latched mode SHALL hold for the whole IRRIGATE state, regardless of input changes.
REQ-026 In IRRIGATE, each tick decrements; a tick at value 1 SHALL enter COOLDOWN and load COOLDOWN_SECONDS; earth_humidity changes SHALL be ignored.
REQ-027 In IRRIGATE, low=0 SHALL enter REFILL next clock.
REQ-028 In IRRIGATE, stop SHALL enter COOLDOWN next clock and load COOLDOWN_SECONDS.
REQ-029 In COOLDOWN, each tick decrements; a tick at value 1 SHALL enter IDLE and pulse cycle_done for exactly that one clock.
REQ-030 cycle_done SHALL NOT pulse after a stop abort or an abort to REFILL or FAULT.
REQ-031 In REFILL, water_supply_valvule SHALL be 1; high=1 with conflict=0 SHALL move to IDLE; remaining_seconds SHALL be 0.
REQ-032 splinker_bomb SHALL be 1 only in IRRIGATE with sprinkler latched; dripper_valvule SHALL be 1 only in IRRIGATE with dripper latched; both outputs SHALL never be 1 together.
REQ-033 alarm SHALL be 1 in FAULT, else ~mid_water_level.
REQ-034 All outputs except alarm SHALL be registered; alarm may be combinational.
REQ-035 Counters SHALL never wrap below 0; a parameter value of 0 SHALL behave as 1.

Reset
REQ-036 While reset_n=0: state=IDLE, all valves 0, remaining_seconds=0, cycle_done=0, latched mode=dripper; alarm follows REQ-033.
REQ-037 Reset assertion mid-IRRIGATE SHALL close valves immediately (asynchronously); no cycle_done pulse.

Verification
REQ-038 Levels low=mid=1, dry soil, dry warm air, ticks -> SETTLE 3 ticks, splinker_bomb=1 for 30 ticks, COOLDOWN 10 ticks, then one cycle_done pulse.
REQ-039 Same stimulus with air_humidity=1 -> dripper_valvule=1 for 90 ticks; toggling air_humidity mid-run leaves the mode unchanged.
REQ-040 IRRIGATE, drive mid=1 with low=0 -> FAULT next clock, valves 0, alarm=1; clear the conflict, then one tick -> IDLE.
REQ-041 IRRIGATE, drop all levels to 0 -> REFILL, water_supply_valvule=1; raise low, mid, high -> IDLE, no cycle_done.
REQ-042 stop at remaining_seconds=12 in IRRIGATE -> COOLDOWN with remaining_seconds=10; tick and stop in the same clock -> stop wins.
REQ-043 Assert reset_n=0 mid-IRRIGATE -> valves 0 without waiting for a clock edge; release -> IDLE, remaining_seconds=0.

Source files
------------

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer
//   Soil-moisture driven irrigation controller. Dry soil is confirmed for
//   SETTLE_TICKS ticks, then either the sprinkler or the dripper runs for its
//   programmed time, followed by a cooldown lockout. Tank level sensors are
//   checked every clock: an inconsistent sensor pattern forces FAULT and an
//   empty tank forces REFILL.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   tick                  one-clock 1 Hz enable, advances all countdowns
//   low/mid/high_water_level  tank sensors, 1 = water present at that level
//   earth_humidity        1 = soil dry (irrigation wanted)
//   air_humidity, low_temperature  either one forbids sprinkler mode
//   stop                  one-clock manual abort request
//   splinker_bomb, dripper_valvule, water_supply_valvule  actuator enables
//   alarm                 FAULT or mid-level warning (combinational)
//   state                 encoded state (IDLE=0 .. FAULT=5)
//   remaining_seconds     current countdown value
//   cycle_done            one-clock pulse when a complete cycle ends
module irrigation_sequencer #(
  parameter int unsigned SETTLE_TICKS     = 3,
  parameter int unsigned SPLINKER_SECONDS = 30,
  parameter int unsigned DRIPPER_SECONDS  = 90,
  parameter int unsigned COOLDOWN_SECONDS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  input  logic       stop,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       water_supply_valvule,
  output logic       alarm,
  output logic [2:0] state,
  output logic [7:0] remaining_seconds,
  output logic       cycle_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETTLE   = 3'd1;
  localparam logic [2:0] S_IRRIGATE = 3'd2;
  localparam logic [2:0] S_COOLDOWN = 3'd3;
  localparam logic [2:0] S_REFILL   = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  // A zero time would otherwise underflow the countdown; treat it as one tick.
  localparam logic [7:0] SETTLE_LD = (SETTLE_TICKS     == 0) ? 8'd1 : 8'(SETTLE_TICKS);
  localparam logic [7:0] SPR_LD    = (SPLINKER_SECONDS == 0) ? 8'd1 : 8'(SPLINKER_SECONDS);
  localparam logic [7:0] DRIP_LD   = (DRIPPER_SECONDS  == 0) ? 8'd1 : 8'(DRIPPER_SECONDS);
  localparam logic [7:0] COOL_LD   = (COOLDOWN_SECONDS == 0) ? 8'd1 : 8'(COOLDOWN_SECONDS);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       spr_mode_q, spr_mode_d;     // 1 = sprinkler, 0 = dripper
  logic       aborted_q, aborted_d;       // cooldown entered via stop
  logic       cycle_done_q, cycle_done_d;
  logic       splinker_q, splinker_d;
  logic       dripper_q, dripper_d;
  logic       supply_q, supply_d;

  logic conflict;
  logic sprinkler_ok;

  // A level sensor reporting water above a dry sensor below it is impossible.
  assign conflict     = (mid_water_level & ~low_water_level) |
                        (high_water_level & ~mid_water_level);
  assign sprinkler_ok = mid_water_level & ~air_humidity & ~low_temperature;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      spr_mode_q   <= 1'b0;
      aborted_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      splinker_q   <= 1'b0;
      dripper_q    <= 1'b0;
      supply_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      spr_mode_q   <= spr_mode_d;
      aborted_q    <= aborted_d;
      cycle_done_q <= cycle_done_d;
      splinker_q   <= splinker_d;
      dripper_q    <= dripper_d;
      supply_q     <= supply_d;
    end
  end

  // Next-state logic: conflict > low-water abort > stop > tick
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    spr_mode_d   = spr_mode_q;
    aborted_d    = aborted_q;
    cycle_done_d = 1'b0;
    if (conflict && (state_q != S_FAULT)) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!low_water_level) begin
            state_d = S_REFILL;
          end else if (earth_humidity) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LD;
          end
        end
        S_SETTLE: begin
          if (!low_water_level) begin
            state_d = S_REFILL;
            cnt_d   = '0;
          end else if (!earth_humidity || stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q <= 8'd1) begin
              state_d    = S_IRRIGATE;
              spr_mode_d = sprinkler_ok;
              cnt_d      = sprinkler_ok ? SPR_LD : DRIP_LD;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_IRRIGATE: begin
          if (!low_water_level) begin
            state_d = S_REFILL;
            cnt_d   = '0;
          end else if (stop) begin
            state_d   = S_COOLDOWN;
            cnt_d     = COOL_LD;
            aborted_d = 1'b1;
          end else if (tick) begin
            if (cnt_q <= 8'd1) begin
              state_d   = S_COOLDOWN;
              cnt_d     = COOL_LD;
              aborted_d = 1'b0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_COOLDOWN: begin
          if (tick) begin
            if (cnt_q <= 8'd1) begin
              state_d      = S_IDLE;
              cnt_d        = '0;
              // Only a naturally completed run counts as a finished cycle.
              cycle_done_d = ~aborted_q;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_REFILL: begin
          cnt_d = '0;
          if (high_water_level) state_d = S_IDLE;
        end
        S_FAULT: begin
          cnt_d = '0;
          if (tick && !conflict) state_d = S_IDLE;
        end
        default: begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic, registered from the next state so actuators track state
  always_comb begin
    splinker_d = (state_d == S_IRRIGATE) &&  spr_mode_d;
    dripper_d  = (state_d == S_IRRIGATE) && !spr_mode_d;
    supply_d   = (state_d == S_REFILL);
  end

  assign splinker_bomb        = splinker_q;
  assign dripper_valvule      = dripper_q;
  assign water_supply_valvule = supply_q;
  assign state                = state_q;
  assign remaining_seconds    = cnt_q;
  assign cycle_done           = cycle_done_q;
  assign alarm                = (state_q == S_FAULT) | ~mid_water_level;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Testbench for irrigation_sequencer: directed scenarios plus a randomized
// run, all compared against a behavioural model of the sequencing rules.
module tb_irrigation_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic tick = 1'b0, low = 1'b0, mid = 1'b0, high = 1'b0;
  logic earth = 1'b0, air = 1'b0, cold = 1'b0, stop = 1'b0;
  logic spr, drip, water, alarm, done;
  logic [2:0] st;
  logic [7:0] rem;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  irrigation_sequencer dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .low_water_level(low), .mid_water_level(mid), .high_water_level(high),
    .earth_humidity(earth), .air_humidity(air), .low_temperature(cold),
    .stop(stop), .splinker_bomb(spr), .dripper_valvule(drip),
    .water_supply_valvule(water), .alarm(alarm), .state(st),
    .remaining_seconds(rem), .cycle_done(done)
  );

  // Behavioural model: phase, countdown, chosen mode, whether the current
  // cooldown came from a manual stop, and the completion pulse.
  localparam int IDLE = 0, SETTLE = 1, IRRIGATE = 2, COOLDOWN = 3, REFILL = 4, FAULT = 5;
  localparam int T_SETTLE = 3, T_SPR = 30, T_DRIP = 90, T_COOL = 10;
  int m_state = IDLE;
  int m_rem = 0;
  bit m_spr = 0, m_abort = 0, m_done = 0;

  task automatic model_reset();
    m_state = IDLE; m_rem = 0; m_spr = 0; m_abort = 0; m_done = 0;
  endtask

  // Advance model and DUT by one clock; inputs are those present before the edge.
  task automatic step();
    int ns, nr;
    bit nspr, nab, nd, conf, ticking_out;
    conf = (mid && !low) || (high && !mid);
    ns = m_state; nr = m_rem; nspr = m_spr; nab = m_abort; nd = 0;
    ticking_out = tick && (m_rem <= 1);
    if (!reset_n) begin
      ns = IDLE; nr = 0; nspr = 0; nab = 0;
    end else if (m_state > FAULT || (conf && m_state != FAULT)) begin
      ns = FAULT; nr = 0;
    end else if (m_state == FAULT) begin
      if (tick && !conf) ns = IDLE;
    end else if (m_state == REFILL) begin
      if (high) ns = IDLE;
    end else if (!low && m_state != COOLDOWN) begin
      ns = REFILL; nr = 0;
    end else if (m_state == IDLE) begin
      if (earth) begin ns = SETTLE; nr = T_SETTLE; end
    end else if (m_state == SETTLE) begin
      if (!earth || stop) begin ns = IDLE; nr = 0; end
      else if (ticking_out) begin
        ns = IRRIGATE; nspr = mid && !air && !cold; nr = nspr ? T_SPR : T_DRIP;
      end else if (tick) nr = m_rem - 1;
    end else if (m_state == IRRIGATE) begin
      if (stop) begin ns = COOLDOWN; nr = T_COOL; nab = 1; end
      else if (ticking_out) begin ns = COOLDOWN; nr = T_COOL; nab = 0; end
      else if (tick) nr = m_rem - 1;
    end else begin
      if (ticking_out) begin ns = IDLE; nr = 0; nd = !m_abort; end
      else if (tick) nr = m_rem - 1;
    end
    @(posedge clock);
    #1;
    m_state = ns; m_rem = nr; m_spr = nspr; m_abort = nab; m_done = nd;
  endtask

  function automatic logic [15:0] exp_vec();
    return {3'(m_state), 8'(m_rem), (m_state == IRRIGATE) && m_spr,
            (m_state == IRRIGATE) && !m_spr, m_state == REFILL, m_done,
            (m_state == FAULT) || !mid};
  endfunction

  function automatic logic [15:0] act_vec();
    return {st, rem, spr, drip, water, done, alarm};
  endfunction

  task automatic go_irrigate();
    low = 1; mid = 1; high = 0; earth = 1; tick = 1; stop = 0;
    for (int i = 0; i < 20 && m_state != IRRIGATE; i++) step();
    tick = 0;
  endtask

  task automatic test_reset();
    low = 1; mid = 0; high = 0; earth = 0;
    #2 reset_n = 0;
    model_reset();
    @(posedge clock); #1;
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_state act=%h exp=%h", act_vec(), exp_vec());
    end
    mid = 1; #1;
    checks++;
    if (alarm !== 1'b0) begin
      failures++; $display("FAIL reset_alarm_mid act=%b exp=0", alarm);
    end
    @(negedge clock);
    reset_n = 1;
    step();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_release act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic run_cycle(input bit humid, input string nm, input int exp_spr, input int exp_drip);
    int settle_t = 0, spr_t = 0, drip_t = 0, cool_t = 0, dones = 0;
    bit fin = 0;
    low = 1; mid = 1; high = 0; earth = 1; air = humid; cold = 0; stop = 0;
    for (int i = 0; i < 600 && !fin; i++) begin
      tick = i[0];
      if (humid) air = (m_state == IRRIGATE) ? 1'($urandom) : 1'b1;
      if (tick) begin
        if (st == 3'd1) settle_t++;
        if (spr) spr_t++;
        if (drip) drip_t++;
        if (st == 3'd3) cool_t++;
      end
      step();
      if (done) dones++;
      fin = m_done;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL %s_step%0d act=%h exp=%h", nm, i, act_vec(), exp_vec());
      end
    end
    earth = 0; tick = 0; air = 0;
    step();
    checks++;
    if (settle_t !== T_SETTLE) begin
      failures++; $display("FAIL %s_settle_ticks act=%0d exp=%0d", nm, settle_t, T_SETTLE);
    end
    checks++;
    if (spr_t !== exp_spr) begin
      failures++; $display("FAIL %s_sprinkler_ticks act=%0d exp=%0d", nm, spr_t, exp_spr);
    end
    checks++;
    if (drip_t !== exp_drip) begin
      failures++; $display("FAIL %s_dripper_ticks act=%0d exp=%0d", nm, drip_t, exp_drip);
    end
    checks++;
    if (cool_t !== T_COOL) begin
      failures++; $display("FAIL %s_cooldown_ticks act=%0d exp=%0d", nm, cool_t, T_COOL);
    end
    checks++;
    if (dones !== 1) begin
      failures++; $display("FAIL %s_done_pulses act=%0d exp=1", nm, dones);
    end
  endtask

  task automatic test_sprinkler();
    run_cycle(1'b0, "sprinkler", T_SPR, 0);
  endtask

  task automatic test_dripper();
    run_cycle(1'b1, "dripper", 0, T_DRIP);
  endtask

  task automatic test_fault();
    air = 0;
    go_irrigate();
    low = 0;
    step();
    checks++;
    if (st !== 3'd5 || spr !== 1'b0 || drip !== 1'b0 || alarm !== 1'b1) begin
      failures++; $display("FAIL fault_entry act=st%0d v%b%b a%b exp=st5 v00 a1", st, spr, drip, alarm);
    end
    low = 1;
    step();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL fault_hold act=%h exp=%h", act_vec(), exp_vec());
    end
    tick = 1; earth = 0;
    step();
    tick = 0;
    checks++;
    if (st !== 3'd0 || rem !== 8'd0) begin
      failures++; $display("FAIL fault_exit act=st%0d rem%0d exp=st0 rem0", st, rem);
    end
  endtask

  task automatic test_refill();
    go_irrigate();
    low = 0; mid = 0; high = 0;
    step();
    checks++;
    if (st !== 3'd4 || water !== 1'b1 || spr !== 1'b0 || rem !== 8'd0) begin
      failures++; $display("FAIL refill_entry act=st%0d w%b s%b rem%0d exp=st4 w1 s0 rem0", st, water, spr, rem);
    end
    earth = 0; low = 1; mid = 1; high = 1;
    step();
    checks++;
    if (st !== 3'd0 || done !== 1'b0 || water !== 1'b0) begin
      failures++; $display("FAIL refill_exit act=st%0d d%b w%b exp=st0 d0 w0", st, done, water);
    end
    high = 0;
    step();
  endtask

  task automatic test_stop();
    int dones = 0;
    go_irrigate();
    tick = 1;
    for (int i = 0; i < 40 && m_rem != 12; i++) step();
    checks++;
    if (rem !== 8'd12) begin
      failures++; $display("FAIL stop_pre_rem act=%0d exp=12", rem);
    end
    stop = 1;
    step();
    stop = 0;
    checks++;
    if (st !== 3'd3 || rem !== 8'd10 || spr !== 1'b0) begin
      failures++; $display("FAIL stop_cooldown act=st%0d rem%0d s%b exp=st3 rem10 s0", st, rem, spr);
    end
    earth = 0;
    for (int i = 0; i < 30 && m_state != IDLE; i++) begin
      step();
      if (done) dones++;
    end
    tick = 0;
    step();
    if (done) dones++;
    checks++;
    if (st !== 3'd0 || dones !== 0) begin
      failures++; $display("FAIL stop_no_done act=st%0d pulses%0d exp=st0 pulses0", st, dones);
    end
  endtask

  task automatic test_async_reset();
    go_irrigate();
    #2 reset_n = 0;
    #1;
    model_reset();
    checks++;
    if (spr !== 1'b0 || drip !== 1'b0 || st !== 3'd0 || rem !== 8'd0) begin
      failures++; $display("FAIL async_reset act=s%b d%b st%0d rem%0d exp=s0 d0 st0 rem0", spr, drip, st, rem);
    end
    step();
    earth = 0;
    @(negedge clock);
    reset_n = 1;
    step();
    checks++;
    if (st !== 3'd0 || rem !== 8'd0 || done !== 1'b0) begin
      failures++; $display("FAIL async_release act=st%0d rem%0d d%b exp=st0 rem0 d0", st, rem, done);
    end
  endtask

  task automatic test_random();
    int lv;
    lv = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lv = int'($urandom_range(0, 99));
      if (lv < 80)      begin low = 1; mid = 1; high = 0; end
      else if (lv < 87) begin low = 0; mid = 0; high = 0; end
      else if (lv < 94) begin low = 1; mid = 1; high = 1; end
      else if (lv < 97) begin low = 0; mid = 1; high = 0; end
      else              begin low = 1; mid = 0; high = 1; end
      tick  = ($urandom_range(0, 2) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      earth = ($urandom_range(0, 9) != 0);
      air   = ($urandom_range(0, 3) == 0);
      cold  = ($urandom_range(0, 5) == 0);
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_cyc%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    tick = 0; stop = 0;
  endtask

  initial begin
    test_reset();
    test_sprinkler();
    test_dripper();
    test_fault();
    test_refill();
    test_stop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
